seg7_scan_capture: RTL and testbench

//  Receive side of the multiplexed 4-digit 7-segment display bus (DIG_1..DIG_4 strobes + LIGHT_SEG).

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_stable_filter.sv | 136 +++++++++++++
 rtl/seg7_scan_capture.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the 7-segment scan capture block.
//               Holds the glyph patterns, the digit index type, the stability
//               filter state encoding and the pattern-to-BCD decoder.
//               Segment order is {g,f,e,d,c,b,a}, bit0 = a.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] c_GLYPH_0     = 7'h3F;
    localparam logic [6:0] c_GLYPH_1     = 7'h06;
    localparam logic [6:0] c_GLYPH_2     = 7'h5B;
    localparam logic [6:0] c_GLYPH_3     = 7'h4F;
    localparam logic [6:0] c_GLYPH_4     = 7'h66;
    localparam logic [6:0] c_GLYPH_5     = 7'h6D;
    localparam logic [6:0] c_GLYPH_6     = 7'h7D;
    localparam logic [6:0] c_GLYPH_7     = 7'h07;
    localparam logic [6:0] c_GLYPH_7_ALT = 7'h27;  // 7 with segment f lit
    localparam logic [6:0] c_GLYPH_8     = 7'h7F;
    localparam logic [6:0] c_GLYPH_9     = 7'h6F;
    localparam logic [6:0] c_GLYPH_9_ALT = 7'h67;  // 9 without segment d
    localparam logic [6:0] c_GLYPH_BLANK = 7'h00;

    localparam logic [3:0] c_BCD_BLANK   = 4'hF;

    // Digit index: 0 = DIG_1 (minutes tens) ... 3 = DIG_4 (seconds units)
    typedef logic [1:0] dig_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } filt_state_e;

    // Returns {legal, value}; value is 4'hF for blank and for illegal patterns.
    function automatic logic [4:0] seg7_to_bcd(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            c_GLYPH_0:                    res = {1'b1, 4'd0};
            c_GLYPH_1:                    res = {1'b1, 4'd1};
            c_GLYPH_2:                    res = {1'b1, 4'd2};
            c_GLYPH_3:                    res = {1'b1, 4'd3};
            c_GLYPH_4:                    res = {1'b1, 4'd4};
            c_GLYPH_5:                    res = {1'b1, 4'd5};
            c_GLYPH_6:                    res = {1'b1, 4'd6};
            c_GLYPH_7, c_GLYPH_7_ALT:     res = {1'b1, 4'd7};
            c_GLYPH_8:                    res = {1'b1, 4'd8};
            c_GLYPH_9, c_GLYPH_9_ALT:     res = {1'b1, 4'd9};
            c_GLYPH_BLANK:                res = {1'b1, c_BCD_BLANK};
            default:                      res = {1'b0, c_BCD_BLANK};
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_stable_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_stable_filter
// Description : Single shared stability filter for the scanned digit bus.
//               Latches the active strobe and its pattern, requires them to
//               hold for STABLE_CYC cycles, then issues one capture per strobe
//               activation. Multiple simultaneous strobes abort the settle.
// Ports       : clk_i       clock, rising edge
//               rst_n_i     asynchronous active-low reset
//               dig_i       strobes, active-high, bit0 = DIG_1
//               pat_i       segment pattern, active-high
//               act_o       new activation accepted this cycle (IDLE -> busy)
//               multi_o     two or more strobes active this cycle
//               cap_o       capture strobe, valid for the current edge
//               cap_idx_o   digit index of the capture
//               cap_pat_o   pattern of the capture
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] dig_i,
    input  logic [6:0] pat_i,
    output logic       act_o,
    output logic       multi_o,
    output logic       cap_o,
    output dig_idx_t   cap_idx_o,
    output logic [6:0] cap_pat_o
);

    localparam int unsigned    c_CNT_W  = $clog2(STABLE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(STABLE_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    filt_state_e          state_q, state_d;
    dig_idx_t             idx_q, idx_d;
    logic [6:0]           pat_q, pat_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;

    logic                 w_any;
    logic                 w_one;
    dig_idx_t             w_idx;
    logic                 w_cap;
    logic                 w_act;

    // Exactly one strobe: non-zero and a power of two.
    assign w_any   = (dig_i != 4'b0000);
    assign w_one   = w_any && ((dig_i & (dig_i - 4'd1)) == 4'b0000);
    assign multi_o = w_any && !w_one;

    always_comb begin
        w_idx = 2'd0;
        case (dig_i)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        w_cap   = 1'b0;
        w_act   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_one) begin
                    w_act = 1'b1;
                    idx_d = w_idx;
                    pat_d = pat_i;
                    cnt_d = c_ONE;
                    // With a one-cycle requirement the first active cycle
                    // already satisfies stability.
                    if (STABLE_CYC == 1) begin
                        w_cap   = 1'b1;
                        state_d = ST_CAPTURED;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_one || (w_idx != idx_q)) begin
                    state_d = ST_IDLE;
                end else if (pat_i != pat_q) begin
                    pat_d = pat_i;
                    cnt_d = c_ONE;
                end else if (cnt_q >= (c_STABLE - c_ONE)) begin
                    cnt_d   = c_STABLE;
                    w_cap   = 1'b1;
                    state_d = ST_CAPTURED;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            ST_CAPTURED: begin
                if (multi_o || !dig_i[idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            pat_q   <= 7'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    // A capture only happens while the live strobe/pattern match the latch,
    // so the live values are the captured ones.
    assign cap_o     = w_cap;
    assign act_o     = w_act;
    assign cap_idx_o = w_idx;
    assign cap_pat_o = pat_i;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Receive-side monitor for a multiplexed 4-digit 7-segment bus.
//               Filters strobe-edge ghosting, decodes each glyph back to BCD,
//               publishes complete MM:SS frames and flags bus errors.
//               The bus is driven from the clk_i domain (no synchronisers).
// Ports       : clk_i            clock, rising edge
//               rst_n_i          asynchronous active-low reset
//               dig1_i..dig4_i   digit strobes (DIG_1 = minutes tens)
//               light_seg_i      segments {g,f,e,d,c,b,a}
//               digit1_o..4_o    last captured value, 0-9 or 4'hF blank
//               frame_valid_o    pulse: all four digits captured
//               frame_changed_o  pulse with frame_valid_o when frame differs
//               seg_err_o        pulse: stable pattern was not a legal glyph
//               sel_err_o        pulse: more than one strobe active
//               scan_lost_o      level: no activation for TIMEOUT_CYC cycles
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          DIG_ACT_LOW = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       dig1_i,
    input  logic       dig2_i,
    input  logic       dig3_i,
    input  logic       dig4_i,
    input  logic [6:0] light_seg_i,
    output logic [3:0] digit1_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit3_o,
    output logic [3:0] digit4_o,
    output logic       frame_valid_o,
    output logic       frame_changed_o,
    output logic       seg_err_o,
    output logic       sel_err_o,
    output logic       scan_lost_o
);

    localparam int unsigned        c_IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT_CYC);

    logic [3:0]          w_dig;
    logic [6:0]          w_pat;
    logic                w_act;
    logic                w_multi;
    logic                w_cap;
    dig_idx_t            w_cap_idx;
    logic [6:0]          w_cap_pat;
    logic                w_legal;
    logic [3:0]          w_val;
    logic [3:0]          w_seen_upd;
    logic                w_frame;
    logic [15:0]         w_frame_vec;

    logic [3:0]          digit_q [4];
    logic [3:0]          digit_d [4];
    logic [3:0]          seen_q, seen_d;
    logic [15:0]         snap_q;
    logic                frame_valid_q;
    logic                frame_changed_q;
    logic                seg_err_q;
    logic                sel_err_q;
    logic [c_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Normalise both buses to active-high before anything else looks at them.
    assign w_dig = DIG_ACT_LOW ? ~{dig4_i, dig3_i, dig2_i, dig1_i}
                               :  {dig4_i, dig3_i, dig2_i, dig1_i};
    assign w_pat = SEG_ACT_LOW ? ~light_seg_i : light_seg_i;

    seg7_stable_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .dig_i      (w_dig),
        .pat_i      (w_pat),
        .act_o      (w_act),
        .multi_o    (w_multi),
        .cap_o      (w_cap),
        .cap_idx_o  (w_cap_idx),
        .cap_pat_o  (w_cap_pat)
    );

    assign {w_legal, w_val} = seg7_to_bcd(w_cap_pat);

    always_comb begin
        digit_d    = digit_q;
        seen_d     = seen_q;
        w_frame    = 1'b0;
        w_seen_upd = seen_q | (4'b0001 << w_cap_idx);
        if (w_cap && w_legal) begin
            digit_d[w_cap_idx] = w_val;
            if (w_seen_upd == 4'hF) begin
                // Frame completes on this edge; start collecting afresh.
                w_frame = 1'b1;
                seen_d  = 4'h0;
            end else begin
                seen_d  = w_seen_upd;
            end
        end
        w_frame_vec = {digit_d[0], digit_d[1], digit_d[2], digit_d[3]};
    end

    // Idle counter restarts on each new activation and saturates otherwise.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (w_act) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q < c_TIMEOUT) begin
            idle_cnt_d = idle_cnt_q + c_IDLE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= c_BCD_BLANK;
            end
            seen_q          <= 4'h0;
            snap_q          <= 16'hFFFF;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            seg_err_q       <= 1'b0;
            sel_err_q       <= 1'b0;
            idle_cnt_q      <= '0;
        end else begin
            digit_q         <= digit_d;
            seen_q          <= seen_d;
            frame_valid_q   <= w_frame;
            frame_changed_q <= w_frame && (w_frame_vec != snap_q);
            if (w_frame) begin
                snap_q <= w_frame_vec;
            end
            seg_err_q       <= w_cap && !w_legal;
            sel_err_q       <= w_multi;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

    assign digit1_o        = digit_q[0];
    assign digit2_o        = digit_q[1];
    assign digit3_o        = digit_q[2];
    assign digit4_o        = digit_q[3];
    assign frame_valid_o   = frame_valid_q;
    assign frame_changed_o = frame_changed_q;
    assign seg_err_o       = seg_err_q;
    assign sel_err_o       = sel_err_q;
    assign scan_lost_o     = (idle_cnt_q >= c_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_capture
// Description : Self-checking bench for seg7_scan_capture. Scans digit
//               sequences from a record table, keeps a scoreboard of
//               expected frames, and exercises stability, select-error,
//               timeout and mid-frame reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int c_STABLE  = 4;
    localparam int c_TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d1, d2, d3, d4;
    logic [6:0] seg;
    logic [3:0] q1, q2, q3, q4;
    logic       fv, fchg, seg_err, sel_err, lost;

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .STABLE_CYC  (c_STABLE),
        .TIMEOUT_CYC (c_TIMEOUT),
        .SEG_ACT_LOW (1'b0),
        .DIG_ACT_LOW (1'b0)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .dig1_i          (d1),
        .dig2_i          (d2),
        .dig3_i          (d3),
        .dig4_i          (d4),
        .light_seg_i     (seg),
        .digit1_o        (q1),
        .digit2_o        (q2),
        .digit3_o        (q3),
        .digit4_o        (q4),
        .frame_valid_o   (fv),
        .frame_changed_o (fchg),
        .seg_err_o       (seg_err),
        .sel_err_o       (sel_err),
        .scan_lost_o     (lost)
    );

    typedef struct {
        int         idx;     // 1..4
        logic [6:0] pat;
        int         hold;    // cycles the strobe stays on
        logic [3:0] val;     // expected DIGIT_idx afterwards
        bit         frame;   // expect one FRAME_VALID during this record
        bit         chg;     // expected FRAME_CHANGED with that frame
        bit         segerr;  // expect one SEG_ERR
    } rec_t;

    typedef struct {
        logic [15:0] frame;
        bit          chg;
    } exp_t;

    rec_t       tbl [$];
    exp_t       exp_q [$];
    int         total = 0;
    int         bad   = 0;
    int         fv_n  = 0;
    int         seg_n = 0;
    int         sel_n = 0;
    logic [3:0] m_dig [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] dig_out(input int idx);
        case (idx)
            1:       return q1;
            2:       return q2;
            3:       return q3;
            default: return q4;
        endcase
    endfunction

    // Advance one clock; sample on the falling edge and pop the scoreboard
    // whenever the DUT publishes a frame.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (fv) begin
                fv_n++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_value", {q1, q2, q3, q4}, e.frame);
                    check("frame_changed", fchg, e.chg);
                end
            end else if (fchg) begin
                check("changed_without_valid", 32'd1, 32'd0);
            end
            seg_n += seg_err;
            sel_n += sel_err;
        end
    endtask

    task automatic set_strobe(input int idx, input logic [6:0] p);
        d1  = (idx == 1);
        d2  = (idx == 2);
        d3  = (idx == 3);
        d4  = (idx == 4);
        seg = p;
    endtask

    task automatic apply(input rec_t r);
        exp_t e;
        int   fv0;
        int   seg0;
        fv0  = fv_n;
        seg0 = seg_n;
        if (r.hold >= c_STABLE && !r.segerr) begin
            m_dig[r.idx-1] = r.val;
        end
        if (r.frame) begin
            e.frame = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
            e.chg   = r.chg;
            exp_q.push_back(e);
        end
        set_strobe(r.idx, r.pat);
        repeat (r.hold) tick();
        set_strobe(0, 7'h00);
        repeat (2) tick();
        check("digit_after_scan", dig_out(r.idx), r.val);
        check("frame_pulses", fv_n - fv0, r.frame ? 1 : 0);
        check("seg_err_pulses", seg_n - seg0, r.segerr ? 1 : 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_strobe(0, 7'h00);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("reset_digits", {q1, q2, q3, q4}, 16'hFFFF);
        check("reset_pulses", {fv, fchg, seg_err, sel_err}, 4'b0000);
        check("reset_scan_lost", lost, 1'b0);
        rst_n = 1'b1;

        // Timeout boundary: idle counter starts at 0 after reset
        repeat (c_TIMEOUT - 1) tick();
        check("scan_lost_before_timeout", lost, 1'b0);
        tick();
        check("scan_lost_at_timeout", lost, 1'b1);
        set_strobe(1, 7'h06);
        tick();
        check("scan_lost_cleared", lost, 1'b0);
        set_strobe(0, 7'h00);
        repeat (2) tick();
        check("one_cycle_no_capture", q1, 4'hF);

        // Table-driven scans
        // "12:34" twice, then "59:07" in reverse order, then an illegal glyph round
        tbl.push_back('{1, 7'h06, 100, 4'h1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 7'h5B, 100, 4'h2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 7'h4F, 100, 4'h3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4, 7'h66, 100, 4'h4, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1, 7'h06, 100, 4'h1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 7'h5B, 100, 4'h2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 7'h4F, 100, 4'h3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4, 7'h66, 100, 4'h4, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{4, 7'h07,  20, 4'h7, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 7'h3F,  20, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 7'h67,  20, 4'h9, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 7'h6D,  20, 4'h5, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{2, 7'h49,  10, 4'h9, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, 7'h00,  10, 4'hF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 7'h3F,  10, 4'h0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4, 7'h27,  10, 4'h7, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 7'h7F,  10, 4'h8, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Stability: 3 cycles is not enough, the 4th edge captures
        set_strobe(3, 7'h66);
        repeat (3) tick();
        set_strobe(0, 7'h00);
        repeat (2) tick();
        check("stab_3_cycles_no_capture", q3, 4'h0);
        set_strobe(3, 7'h66);
        repeat (3) tick();
        check("stab_before_4th_edge", q3, 4'h0);
        tick();
        check("stab_on_4th_edge", q3, 4'h4);
        set_strobe(0, 7'h00);
        repeat (2) tick();
        // Pattern change under the same strobe restarts the count
        set_strobe(3, 7'h06);
        repeat (2) tick();
        set_strobe(3, 7'h5B);
        repeat (3) tick();
        check("restart_not_yet", q3, 4'h4);
        tick();
        check("restart_capture", q3, 4'h2);
        m_dig[2] = 4'h2;
        set_strobe(0, 7'h00);
        repeat (2) tick();

        // Select error during settle, then a clean restart
        set_strobe(1, 7'h06);
        repeat (2) tick();
        d2 = 1'b1;
        tick();
        check("sel_err_pulse", sel_err, 1'b1);
        set_strobe(1, 7'h06);
        tick();
        check("sel_err_cleared", sel_err, 1'b0);
        repeat (2) tick();
        check("sel_restart_not_yet", q1, 4'hF);
        tick();
        check("sel_restart_capture", q1, 4'h1);
        m_dig[0] = 4'h1;
        set_strobe(0, 7'h00);
        repeat (2) tick();
        check("sel_err_count", sel_n, 1);
        apply('{2, 7'h4F, 10, 4'h3, 1'b0, 1'b0, 1'b0});
        apply('{4, 7'h3F, 10, 4'h0, 1'b1, 1'b1, 1'b0});

        // Reset mid-frame discards the partial frame
        apply('{1, 7'h06, 10, 4'h1, 1'b0, 1'b0, 1'b0});
        apply('{2, 7'h5B, 10, 4'h2, 1'b0, 1'b0, 1'b0});
        set_strobe(3, 7'h4F);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_digits", {q1, q2, q3, q4}, 16'hFFFF);
        check("async_reset_flags", {fv, seg_err, sel_err, lost}, 4'b0000);
        set_strobe(0, 7'h00);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
        tick();
        rst_n = 1'b1;
        apply('{3, 7'h4F, 10, 4'h3, 1'b0, 1'b0, 1'b0});
        apply('{4, 7'h66, 10, 4'h4, 1'b0, 1'b0, 1'b0});
        apply('{1, 7'h06, 10, 4'h1, 1'b0, 1'b0, 1'b0});
        apply('{2, 7'h5B, 10, 4'h2, 1'b1, 1'b1, 1'b0});

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
